// File: rtl/simple_isa_pkg.sv
// simple_isa_pkg: opcode constants, condition codes, ALU flag bit positions
// and the branch resolver state encoding for the SIMPLE ISA.
package simple_isa_pkg;

    localparam logic [4:0] OP_B   = 5'b10100;
    localparam logic [4:0] OP_BCC = 5'b10111;

    localparam logic [2:0] COND_BE  = 3'b000;
    localparam logic [2:0] COND_BLT = 3'b001;
    localparam logic [2:0] COND_BLE = 3'b010;
    localparam logic [2:0] COND_BNE = 3'b011;

    // flags word is {S,Z,C,V}
    localparam int unsigned FLAG_S = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_FLAGS,
        ST_ISSUE,
        ST_SQUASH
    } br_state_t;

endpackage

// File: rtl/branch_cond_eval.sv
// branch_cond_eval: combinational condition check of a Bcc condition code
// against ALU flags {S,Z,C,V}. Codes 100..111 are never taken.
module branch_cond_eval
    import simple_isa_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [3:0] flags,
    output logic       taken
);

    logic s_bit, z_bit, v_bit;
    logic unused_carry;

    assign s_bit        = flags[FLAG_S];
    assign z_bit        = flags[FLAG_Z];
    assign v_bit        = flags[FLAG_V];
    assign unused_carry = flags[FLAG_C];

    // Condition table lookup
    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_BE:  taken = z_bit;
            COND_BLT: taken = s_bit ^ v_bit;
            COND_BLE: taken = z_bit | (s_bit ^ v_bit);
            COND_BNE: taken = ~z_bit;
            default:  taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/p1_branch_resolver.sv
// p1_branch_resolver: decodes B/Bcc from the fetch stage, waits for ALU flags,
// drives the PC redirect and squashes SHADOW wrong-path operations afterwards.
// Optional statistics counters are enabled with `define P1_BRANCH_STATS_EN.
module p1_branch_resolver
    import simple_isa_pkg::*;
#(
    parameter int unsigned SHADOW = 2,
    parameter int unsigned WIDTH  = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             op_valid,
    input  logic [WIDTH-1:0] operation,
    input  logic [WIDTH-1:0] pcin,
    output logic             op_ready,
    input  logic             flags_valid,
    input  logic [3:0]       flags,
    output logic             pcsrcout,
    output logic [WIDTH-1:0] pctargetout,
    input  logic             redirect_ack,
    output logic             squash,
    output logic [WIDTH-1:0] branch_pc
`ifdef P1_BRANCH_STATS_EN
    ,
    output logic [15:0]      taken_cnt,
    output logic [15:0]      nottaken_cnt,
    output logic [15:0]      squash_cnt
`endif
);

    localparam int unsigned CW = (SHADOW < 2) ? 1 : $clog2(SHADOW + 1);

    br_state_t     state;
    logic [2:0]    cond_q;
    logic [7:0]    offset_q;
    logic [CW-1:0] shadow_cnt;
    logic          is_b;
    logic          is_bcc;
    logic          cond_taken;

    function automatic logic [WIDTH-1:0] sext8(input logic [7:0] off);
        return {{(WIDTH-8){off[7]}}, off};
    endfunction

    assign is_b     = (operation[15:11] == OP_B);
    assign is_bcc   = (operation[15:11] == OP_BCC);
    assign op_ready = (state == ST_IDLE) || (state == ST_SQUASH);
    assign squash   = (state == ST_SQUASH) && op_valid;

    branch_cond_eval u_cond (
        .cond  (cond_q),
        .flags (flags),
        .taken (cond_taken)
    );

    // Resolver FSM with registered redirect outputs and wrong-path counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            cond_q      <= '0;
            offset_q    <= '0;
            shadow_cnt  <= '0;
            pcsrcout    <= 1'b0;
            pctargetout <= '0;
            branch_pc   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (op_valid) begin
                        if (is_b) begin
                            branch_pc   <= pcin;
                            offset_q    <= operation[7:0];
                            pctargetout <= sext8(operation[7:0]);
                            pcsrcout    <= 1'b1;
                            state       <= ST_ISSUE;
                        end else if (is_bcc) begin
                            branch_pc <= pcin;
                            offset_q  <= operation[7:0];
                            cond_q    <= operation[10:8];
                            state     <= ST_WAIT_FLAGS;
                        end
                    end
                end
                ST_WAIT_FLAGS: begin
                    if (flags_valid) begin
                        if (cond_taken) begin
                            pctargetout <= sext8(offset_q);
                            pcsrcout    <= 1'b1;
                            state       <= ST_ISSUE;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (redirect_ack) begin
                        pcsrcout <= 1'b0;
                        if (SHADOW == 0) begin
                            state <= ST_IDLE;
                        end else begin
                            shadow_cnt <= CW'(SHADOW);
                            state      <= ST_SQUASH;
                        end
                    end
                end
                ST_SQUASH: begin
                    if (op_valid) begin
                        shadow_cnt <= shadow_cnt - 1'b1;
                        if (shadow_cnt == CW'(1)) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef P1_BRANCH_STATS_EN
    logic ev_taken;
    logic ev_nottaken;

    // Resolution events feeding the statistics counters
    always_comb begin
        ev_taken    = ((state == ST_IDLE) && op_valid && is_b) ||
                      ((state == ST_WAIT_FLAGS) && flags_valid && cond_taken);
        ev_nottaken = (state == ST_WAIT_FLAGS) && flags_valid && !cond_taken;
    end

    // Saturating statistics counters
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            taken_cnt    <= '0;
            nottaken_cnt <= '0;
            squash_cnt   <= '0;
        end else begin
            if (ev_taken && (taken_cnt != '1))
                taken_cnt <= taken_cnt + 16'd1;
            if (ev_nottaken && (nottaken_cnt != '1))
                nottaken_cnt <= nottaken_cnt + 16'd1;
            if (squash && (squash_cnt != '1))
                squash_cnt <= squash_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_p1_branch_resolver.sv
// tb_p1_branch_resolver: directed tests for p1_branch_resolver (SHADOW=2, WIDTH=16).
// Statistics tests are included when P1_BRANCH_STATS_EN is defined.
module tb_p1_branch_resolver;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        op_valid;
    logic [15:0] operation;
    logic [15:0] pcin;
    logic        op_ready;
    logic        flags_valid;
    logic [3:0]  flags;
    logic        pcsrcout;
    logic [15:0] pctargetout;
    logic        redirect_ack;
    logic        squash;
    logic [15:0] branch_pc;
`ifdef P1_BRANCH_STATS_EN
    logic [15:0] taken_cnt;
    logic [15:0] nottaken_cnt;
    logic [15:0] squash_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    p1_branch_resolver #(.SHADOW(2), .WIDTH(16)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .op_valid     (op_valid),
        .operation    (operation),
        .pcin         (pcin),
        .op_ready     (op_ready),
        .flags_valid  (flags_valid),
        .flags        (flags),
        .pcsrcout     (pcsrcout),
        .pctargetout  (pctargetout),
        .redirect_ack (redirect_ack),
        .squash       (squash),
        .branch_pc    (branch_pc)
`ifdef P1_BRANCH_STATS_EN
        ,
        .taken_cnt    (taken_cnt),
        .nottaken_cnt (nottaken_cnt),
        .squash_cnt   (squash_cnt)
`endif
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs;
        op_valid     = 1'b0;
        operation    = 16'h0000;
        pcin         = 16'h0000;
        flags_valid  = 1'b0;
        flags        = 4'h0;
        redirect_ack = 1'b0;
    endtask

    // From ISSUE: acknowledge, then feed two non-branch ops through the shadow
    task automatic ack_and_drain;
        redirect_ack = 1'b1;
        tick;
        redirect_ack = 1'b0;
        op_valid  = 1'b1;
        operation = 16'h0001;
        tick;
        tick;
        op_valid  = 1'b0;
    endtask

    task automatic test_reset;
        idle_inputs;
        reset_n = 1'b0;
        tick;
        tick;
        checks++; if (pcsrcout !== 1'b0) begin errors++; $display("FAIL reset_pcsrc: got %b want 0", pcsrcout); end
        checks++; if (pctargetout !== 16'h0000) begin errors++; $display("FAIL reset_target: got %h want 0000", pctargetout); end
        checks++; if (squash !== 1'b0) begin errors++; $display("FAIL reset_squash: got %b want 0", squash); end
        checks++; if (branch_pc !== 16'h0000) begin errors++; $display("FAIL reset_branch_pc: got %h want 0000", branch_pc); end
        reset_n = 1'b1;
        tick;
        checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL reset_op_ready: got %b want 1", op_ready); end
    endtask

    task automatic test_uncond_b;
        op_valid = 1'b1; operation = 16'hA005; pcin = 16'h0100;
        #1;
        checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL b_ready: got %b want 1", op_ready); end
        tick;
        op_valid = 1'b0;
        checks++; if (pcsrcout !== 1'b1) begin errors++; $display("FAIL b_pcsrc: got %b want 1", pcsrcout); end
        checks++; if (pctargetout !== 16'h0005) begin errors++; $display("FAIL b_target: got %h want 0005", pctargetout); end
        checks++; if (branch_pc !== 16'h0100) begin errors++; $display("FAIL b_branch_pc: got %h want 0100", branch_pc); end
        checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL b_issue_ready: got %b want 0", op_ready); end
        tick;
        tick;
        checks++; if (pcsrcout !== 1'b1) begin errors++; $display("FAIL b_hold_pcsrc: got %b want 1", pcsrcout); end
        checks++; if (pctargetout !== 16'h0005) begin errors++; $display("FAIL b_hold_target: got %h want 0005", pctargetout); end
        redirect_ack = 1'b1;
        #1;
        checks++; if (pcsrcout !== 1'b1) begin errors++; $display("FAIL b_ack_cycle: got %b want 1", pcsrcout); end
        tick;
        redirect_ack = 1'b0;
        checks++; if (pcsrcout !== 1'b0) begin errors++; $display("FAIL b_after_ack: got %b want 0", pcsrcout); end
        checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL squash_ready: got %b want 1", op_ready); end
    endtask

    // Continues from the SQUASH state left by test_uncond_b
    task automatic test_squash;
        op_valid = 1'b1; operation = 16'hA005; pcin = 16'h0300;
        #1;
        checks++; if (squash !== 1'b1) begin errors++; $display("FAIL squash_first: got %b want 1", squash); end
        tick;
        operation = 16'h1234; pcin = 16'h0301;
        #1;
        checks++; if (squash !== 1'b1) begin errors++; $display("FAIL squash_second: got %b want 1", squash); end
        checks++; if (pcsrcout !== 1'b0) begin errors++; $display("FAIL squash_b_ignored: got %b want 0", pcsrcout); end
        tick;
        operation = 16'h2222; pcin = 16'h0302;
        #1;
        checks++; if (squash !== 1'b0) begin errors++; $display("FAIL squash_third: got %b want 0", squash); end
        checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL squash_third_ready: got %b want 1", op_ready); end
        tick;
        op_valid = 1'b0;
        checks++; if (pcsrcout !== 1'b0) begin errors++; $display("FAIL squash_idle_pcsrc: got %b want 0", pcsrcout); end
        checks++; if (branch_pc !== 16'h0100) begin errors++; $display("FAIL squash_branch_pc: got %h want 0100", branch_pc); end
    endtask

    task automatic test_be_taken;
        op_valid = 1'b1; operation = 16'hB8FE; pcin = 16'h0200;
        tick;
        op_valid = 1'b0;
        checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL be_wait_ready: got %b want 0", op_ready); end
        checks++; if (pcsrcout !== 1'b0) begin errors++; $display("FAIL be_wait_pcsrc: got %b want 0", pcsrcout); end
        redirect_ack = 1'b1;
        tick;
        redirect_ack = 1'b0;
        checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL be_ack_ignored: got %b want 0", op_ready); end
        flags_valid = 1'b1; flags = 4'b0100;
        tick;
        flags_valid = 1'b0; flags = 4'h0;
        checks++; if (pcsrcout !== 1'b1) begin errors++; $display("FAIL be_pcsrc: got %b want 1", pcsrcout); end
        checks++; if (pctargetout !== 16'hFFFE) begin errors++; $display("FAIL be_target: got %h want FFFE", pctargetout); end
        checks++; if (branch_pc !== 16'h0200) begin errors++; $display("FAIL be_branch_pc: got %h want 0200", branch_pc); end
        ack_and_drain;
    endtask

    task automatic test_bne_not_taken;
        op_valid = 1'b1; operation = 16'hBB10; pcin = 16'h0400;
        tick;
        operation = 16'hA005; op_valid = 1'b1;
        flags_valid = 1'b1; flags = 4'b0100;
        #1;
        checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL bne_simul_ready: got %b want 0", op_ready); end
        tick;
        idle_inputs;
        checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL bne_back_idle: got %b want 1", op_ready); end
        checks++; if (pcsrcout !== 1'b0) begin errors++; $display("FAIL bne_pcsrc: got %b want 0", pcsrcout); end
        tick;
        checks++; if (pcsrcout !== 1'b0) begin errors++; $display("FAIL bne_dropped_op: got %b want 0", pcsrcout); end
    endtask

    task automatic test_cond_table;
        logic [15:0] ops   [8] = '{16'hB905, 16'hB905, 16'hBA05, 16'hBA05,
                                   16'hB805, 16'hBB05, 16'hBC05, 16'hBF05};
        logic [3:0]  fls   [8] = '{4'b1000, 4'b1001, 4'b0001, 4'b0000,
                                   4'b1011, 4'b0000, 4'b1111, 4'b1111};
        logic        exp_t [8] = '{1'b1, 1'b0, 1'b1, 1'b0,
                                   1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            op_valid = 1'b1; operation = ops[i]; pcin = 16'h0500 + 16'(i);
            tick;
            op_valid = 1'b0;
            flags_valid = 1'b1; flags = fls[i];
            tick;
            flags_valid = 1'b0; flags = 4'h0;
            checks++;
            if (pcsrcout !== exp_t[i]) begin
                errors++;
                $display("FAIL cond_%0d op=%h flags=%b: got %b want %b", i, ops[i], fls[i], pcsrcout, exp_t[i]);
            end
            if (exp_t[i]) ack_and_drain;
        end
    endtask

    task automatic test_offset_boundary;
        op_valid = 1'b1; operation = 16'hA080; pcin = 16'h0600;
        tick;
        op_valid = 1'b0;
        checks++; if (pctargetout !== 16'hFF80) begin errors++; $display("FAIL off_80: got %h want FF80", pctargetout); end
        ack_and_drain;
        op_valid = 1'b1; operation = 16'hA07F; pcin = 16'h0601;
        tick;
        op_valid = 1'b0;
        checks++; if (pctargetout !== 16'h007F) begin errors++; $display("FAIL off_7F: got %h want 007F", pctargetout); end
        ack_and_drain;
    endtask

    task automatic test_nonbranch;
        op_valid = 1'b1; operation = 16'hA800; pcin = 16'h0700;
        tick;
        op_valid = 1'b0;
        checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL nonbr_ready: got %b want 1", op_ready); end
        checks++; if (pcsrcout !== 1'b0) begin errors++; $display("FAIL nonbr_pcsrc: got %b want 0", pcsrcout); end
    endtask

    task automatic test_reset_mid_issue;
        op_valid = 1'b1; operation = 16'hA033; pcin = 16'h0800;
        tick;
        op_valid = 1'b0;
        checks++; if (pcsrcout !== 1'b1) begin errors++; $display("FAIL rst_pre_pcsrc: got %b want 1", pcsrcout); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (pcsrcout !== 1'b0) begin errors++; $display("FAIL rst_async_pcsrc: got %b want 0", pcsrcout); end
        checks++; if (pctargetout !== 16'h0000) begin errors++; $display("FAIL rst_async_target: got %h want 0000", pctargetout); end
        checks++; if (branch_pc !== 16'h0000) begin errors++; $display("FAIL rst_async_branch_pc: got %h want 0000", branch_pc); end
        #1;
        reset_n = 1'b1;
        tick;
        checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", op_ready); end
        tick;
        checks++; if (pcsrcout !== 1'b0) begin errors++; $display("FAIL rst_no_redirect: got %b want 0", pcsrcout); end
    endtask

`ifdef P1_BRANCH_STATS_EN
    task automatic test_stats;
        idle_inputs;
        reset_n = 1'b0;
        tick;
        checks++; if (taken_cnt !== 16'd0) begin errors++; $display("FAIL stats_reset: got %0d want 0", taken_cnt); end
        reset_n = 1'b1;
        tick;
        op_valid = 1'b1; operation = 16'hA001; tick; op_valid = 1'b0; ack_and_drain;
        op_valid = 1'b1; operation = 16'hA002; tick; op_valid = 1'b0; ack_and_drain;
        op_valid = 1'b1; operation = 16'hB803; tick; op_valid = 1'b0;
        flags_valid = 1'b1; flags = 4'b0100; tick; flags_valid = 1'b0; ack_and_drain;
        op_valid = 1'b1; operation = 16'hBB04; tick; op_valid = 1'b0;
        flags_valid = 1'b1; flags = 4'b0100; tick; flags_valid = 1'b0; flags = 4'h0;
        checks++; if (taken_cnt !== 16'd3) begin errors++; $display("FAIL stats_taken: got %0d want 3", taken_cnt); end
        checks++; if (nottaken_cnt !== 16'd1) begin errors++; $display("FAIL stats_nottaken: got %0d want 1", nottaken_cnt); end
        checks++; if (squash_cnt !== 16'd6) begin errors++; $display("FAIL stats_squash: got %0d want 6", squash_cnt); end
    endtask
`endif

    initial begin
        idle_inputs;
        reset_n = 1'b0;
        test_reset;
        test_uncond_b;
        test_squash;
        test_be_taken;
        test_bne_not_taken;
        test_cond_table;
        test_offset_boundary;
        test_nonbranch;
        test_reset_mid_issue;
`ifdef P1_BRANCH_STATS_EN
        test_stats;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
